// File: rtl/gearbox_nm.sv
// Width-conversion gearbox: repacks IN_W-bit words into OUT_W-bit words LSB-first,
// with valid/ready on both sides and a zero-padded partial word at packet end.
module gearbox_nm #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32,
  parameter int BUF_W = 2*(IN_W+OUT_W),
  parameter int CNT_W = $clog2(BUF_W+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [$clog2(OUT_W+1)-1:0] out_vbits,
  input  logic                       out_ready
);
  localparam int VB_W = $clog2(OUT_W+1);
  localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] ROOM_C = CNT_W'(BUF_W-IN_W);

  logic [BUF_W-1:0] sbuf;
  logic [CNT_W-1:0] fill;
  logic             flush;
  logic             reset_q;

  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] consume;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] fill_next;
  logic [BUF_W-1:0] buf_next;

  // Handshake contract: a word moves on a side exactly when valid & ready are both
  // high at a rising edge; in_ready depends only on registered state (and reset).
  always_comb begin
    in_ready  = !reset && !reset_q && !flush && (fill <= ROOM_C);
    out_valid = (fill >= OUT_C) || (flush && (fill != '0));
    out_last  = flush && (fill <= OUT_C) && (fill != '0);
    if (!out_valid)
      out_vbits = '0;
    else if (out_last)
      out_vbits = fill[VB_W-1:0];
    else
      out_vbits = VB_W'(OUT_W);
    out_data  = sbuf[OUT_W-1:0];
  end

  always_comb begin
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    consume   = out_fire ? (out_last ? fill : OUT_C) : '0;
    base      = fill - consume;
    fill_next = base + (in_fire ? IN_C : '0);
    buf_next  = sbuf >> consume;
    if (in_fire)
      buf_next = buf_next | (BUF_W'(in_data) << base);
    // Keep everything above the fill level zero so a partial last word is padded.
    buf_next  = buf_next & ~({BUF_W{1'b1}} << fill_next);
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      sbuf  <= '0;
      fill  <= '0;
      flush <= 1'b0;
    end else begin
      sbuf <= buf_next;
      fill <= fill_next;
      if (in_fire && in_last)
        flush <= 1'b1;
      else if (out_fire && out_last)
        flush <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gearbox_nm.sv
// Bench for gearbox_nm: three instances (24->32, 32->24, 10->8) driven one at a time,
// checked against directed tables and a bit-queue reference model.
module tb_gearbox_nm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  localparam int IN_W_A[3]  = '{24, 32, 10};
  localparam int OUT_W_A[3] = '{32, 24, 8};

  logic [31:0] in_data [3];
  logic        in_valid [3];
  logic        in_last [3];
  logic        out_ready [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic        out_last [3];
  logic [31:0] od0;
  logic [23:0] od1;
  logic [7:0]  od2;
  logic [5:0]  vb0;
  logic [4:0]  vb1;
  logic [3:0]  vb2;

  gearbox_nm #(.IN_W(24), .OUT_W(32)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data[0][23:0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .out_data(od0), .out_valid(out_valid[0]),
    .out_last(out_last[0]), .out_vbits(vb0), .out_ready(out_ready[0]));
  gearbox_nm #(.IN_W(32), .OUT_W(24)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .out_data(od1), .out_valid(out_valid[1]),
    .out_last(out_last[1]), .out_vbits(vb1), .out_ready(out_ready[1]));
  gearbox_nm #(.IN_W(10), .OUT_W(8)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data[2][9:0]), .in_valid(in_valid[2]),
    .in_last(in_last[2]), .in_ready(in_ready[2]), .out_data(od2), .out_valid(out_valid[2]),
    .out_last(out_last[2]), .out_vbits(vb2), .out_ready(out_ready[2]));

  int tests = 0;
  int fails = 0;
  int max_fill [3] = '{0, 0, 0};

  logic [31:0] in_words_q[$];
  bit          in_last_q[$];
  logic [31:0] exp_q[$];
  bit          exp_last_q[$];
  int          exp_vb_q[$];

  typedef struct {
    int          k;
    int          n_in;
    logic [31:0] din [4];
    int          n_out;
    logic [31:0] dout [3];
    int          last_vb;
  } vec_t;
  vec_t vecs [3];

  function automatic logic [31:0] get_od(input int k);
    case (k)
      0: return od0;
      1: return {8'h0, od1};
      default: return {24'h0, od2};
    endcase
  endfunction

  function automatic int get_vb(input int k);
    case (k)
      0: return int'(vb0);
      1: return int'(vb1);
      default: return int'(vb2);
    endcase
  endfunction

  function automatic int get_fill(input int k);
    case (k)
      0: return int'(u0.fill);
      1: return int'(u1.fill);
      default: return int'(u2.fill);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (get_fill(k) > max_fill[k]) max_fill[k] = get_fill(k);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int k);
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
    in_data[k]  = '0;
    out_ready[k] = 1'b0;
  endtask

  // Reference: concatenate the packet's bits, cut into OUT_W chunks, pad the tail.
  task automatic build_exp(input int k);
    bit bq[$];
    logic [31:0] w;
    int n;
    exp_q.delete();
    exp_last_q.delete();
    exp_vb_q.delete();
    for (int i = 0; i < in_words_q.size(); i++) begin
      for (int b = 0; b < IN_W_A[k]; b++) bq.push_back(in_words_q[i][b]);
      while (bq.size() >= OUT_W_A[k] || (in_last_q[i] && bq.size() > 0)) begin
        w = '0;
        n = (bq.size() < OUT_W_A[k]) ? bq.size() : OUT_W_A[k];
        for (int b = 0; b < n; b++) w[b] = bq.pop_front();
        exp_q.push_back(w);
        exp_vb_q.push_back(n);
        exp_last_q.push_back(in_last_q[i] && bq.size() == 0);
      end
    end
  endtask

  task automatic gen_pkts(input int k, input int npk);
    logic [63:0] m;
    int len;
    m = (64'd1 << IN_W_A[k]) - 64'd1;
    in_words_q.delete();
    in_last_q.delete();
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        in_words_q.push_back($urandom() & m[31:0]);
        in_last_q.push_back(w == len - 1);
      end
    end
  endtask

  task automatic run_stream(input int k, input int vp, input int rp, input int hold,
                            input int max_cyc);
    int wi, cyc, lasts, npk;
    logic [31:0] e;
    build_exp(k);
    wi = 0; cyc = 0; lasts = 0; npk = 0;
    foreach (in_last_q[i]) if (in_last_q[i]) npk++;
    while ((wi < in_words_q.size() || exp_q.size() > 0) && cyc < max_cyc) begin
      @(negedge clk);
      in_valid[k]  = (wi < in_words_q.size()) && ($urandom_range(99) < vp);
      in_data[k]   = (wi < in_words_q.size()) ? in_words_q[wi] : '0;
      in_last[k]   = (wi < in_words_q.size()) ? in_last_q[wi] : 1'b0;
      out_ready[k] = (cyc >= hold) && ($urandom_range(99) < rp);
      #1;
      if (hold > 0 && cyc == hold) begin
        chk("bp_accepted", wi, (2*(IN_W_A[k]+OUT_W_A[k])) / IN_W_A[k]);
        chk("bp_in_ready", in_ready[k], 1'b0);
        chk("bp_out_valid", out_valid[k], 1'b1);
        chk("bp_data", get_od(k), exp_q[0]);
      end
      if (in_valid[k] && in_ready[k]) wi++;
      if (out_valid[k] && out_ready[k]) begin
        if (out_last[k]) lasts++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_extra: got word %0h, expected none", get_od(k));
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", get_od(k), e);
          chk("sb_last", out_last[k], exp_last_q.pop_front());
          chk("sb_vbits", get_vb(k), exp_vb_q.pop_front());
        end
      end
      cyc++;
    end
    @(negedge clk);
    idle(k);
    chk("stream_timeout", cyc < max_cyc, 1'b1);
    chk("sb_drained", exp_q.size(), 0);
    chk("pkt_lasts", lasts, npk);
  endtask

  task automatic run_vec(input vec_t v);
    int k, i, ncyc;
    bit drop, early, last_acc;
    logic [31:0] gd[$];
    bit gl[$];
    int gv[$];
    k = v.k; i = 0; ncyc = 0; drop = 0; early = 0; last_acc = 0;
    while (gd.size() < v.n_out && ncyc < 60) begin
      @(negedge clk);
      in_valid[k]  = (i < v.n_in);
      in_data[k]   = (i < v.n_in) ? v.din[i] : '0;
      in_last[k]   = (i == v.n_in - 1);
      out_ready[k] = 1'b1;
      #1;
      if (last_acc && in_ready[k]) early = 1;
      if (in_valid[k] && !in_ready[k]) drop = 1;
      if (in_valid[k] && in_ready[k]) begin
        if (in_last[k]) last_acc = 1;
        i++;
      end
      if (out_valid[k]) begin
        gd.push_back(get_od(k));
        gl.push_back(out_last[k]);
        gv.push_back(get_vb(k));
      end
      ncyc++;
    end
    @(negedge clk);
    idle(k);
    #1;
    chk("vec_in_ready_reopen", in_ready[k], 1'b1);
    chk("vec_word_count", gd.size(), v.n_out);
    chk("vec_in_ready_steady", drop, 1'b0);
    chk("vec_in_ready_blocked", early, 1'b0);
    for (int j = 0; j < gd.size(); j++) begin
      chk("vec_data", gd[j], v.dout[j]);
      chk("vec_last", gl[j], j == v.n_out - 1);
      chk("vec_vbits", gv[j], (j == v.n_out - 1) ? v.last_vb : OUT_W_A[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) idle(k);

    vecs[0].k = 0; vecs[0].n_in = 4; vecs[0].n_out = 3; vecs[0].last_vb = 32;
    vecs[0].din  = '{32'hAAAAAA, 32'hBBBBBB, 32'hCCCCCC, 32'hDDDDDD};
    vecs[0].dout = '{32'hBBAAAAAA, 32'hCCCCBBBB, 32'hDDDDDDCC};
    vecs[1].k = 0; vecs[1].n_in = 3; vecs[1].n_out = 3; vecs[1].last_vb = 8;
    vecs[1].din  = '{32'h111111, 32'h222222, 32'h333333, 32'h0};
    vecs[1].dout = '{32'h22111111, 32'h33332222, 32'h00000033};
    vecs[2].k = 1; vecs[2].n_in = 2; vecs[2].n_out = 3; vecs[2].last_vb = 16;
    vecs[2].din  = '{32'h44332211, 32'h88776655, 32'h0, 32'h0};
    vecs[2].dout = '{32'h332211, 32'h665544, 32'h008877};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready_during", in_ready[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready_after", in_ready[k], 1'b0);
      chk("rst_out_valid", out_valid[k], 1'b0);
      chk("rst_out_last", out_last[k], 1'b0);
      chk("rst_out_vbits", get_vb(k), 0);
      chk("rst_out_data", get_od(k), 0);
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("rst_in_ready_rise", in_ready[k], 1'b1);

    for (int v = 0; v < 3; v++) run_vec(vecs[v]);

    in_words_q = '{32'hAAAAAA, 32'hBBBBBB, 32'hCCCCCC, 32'hDDDDDD,
                   32'hEEEEEE, 32'hFFFFFF, 32'h111111, 32'h222222};
    in_last_q  = '{0, 0, 0, 0, 0, 0, 0, 1};
    run_stream(0, 100, 100, 8, 400);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_last[0] = 1'b0; out_ready[0] = 1'b1;
      in_data[0] = 32'h5A5A5A ^ i;
    end
    @(negedge clk);
    idle(0);
    #1;
    chk("mid_fill_before_reset", get_fill(0), 40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid[0], 1'b0);
    chk("mid_rst_in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    #1;
    chk("mid_rst_in_ready_rise", in_ready[0], 1'b1);
    in_words_q = '{32'h123456, 32'h789ABC, 32'hDEF012};
    in_last_q  = '{0, 0, 1};
    run_stream(0, 100, 100, 0, 200);

    gen_pkts(0, 1000);
    run_stream(0, 70, 70, 0, 40000);
    gen_pkts(1, 150);
    run_stream(1, 70, 70, 0, 8000);
    gen_pkts(2, 1000);
    run_stream(2, 70, 70, 0, 40000);

    chk("fill_bound_u0", max_fill[0] <= 112, 1'b1);
    chk("fill_bound_u1", max_fill[1] <= 112, 1'b1);
    chk("fill_bound_u2", max_fill[2] <= 36, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
